// File: rtl/yutorina_bus_arbiter.sv
// Round-robin bus arbiter for yutorina_bus: registered one-cold grants, ownership held
// while the owner requests, optional hold limit that preempts between transfers.
module yutorina_bus_arbiter #(
    parameter int NUM_M    = 4,
    parameter int OWN_W    = 2,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_M-1:0] req_,
    input  logic             s_as_,
    output logic [NUM_M-1:0] grnt_,
    output logic [OWN_W-1:0] owner,
    output logic             owner_vld
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] hold_max = CNT_W'(MAX_HOLD);
    localparam logic             hold_en  = (MAX_HOLD != 0);

    state_t           state;
    logic [OWN_W-1:0] last;
    logic [CNT_W-1:0] cnt;

    logic [NUM_M-1:0]   req;
    logic [2*NUM_M-1:0] rot_full;
    logic [NUM_M-1:0]   rot;
    logic [OWN_W:0]     rot_sh;
    logic               oth_any, all_any;
    logic [OWN_W-1:0]   oth_off, all_off;
    logic [OWN_W-1:0]   oth_win, all_win;
    logic               owner_req;
    logic               preempt;

    // Offset k into the rotated vector is master (last + 1 + k) mod NUM_M.
    function automatic logic [OWN_W-1:0] off_to_idx(input logic [OWN_W-1:0] base,
                                                    input logic [OWN_W-1:0] off);
        logic [OWN_W:0] s;
        s = {1'b0, base} + {1'b0, off} + (OWN_W+1)'(1);
        if (s >= (OWN_W+1)'(NUM_M))
            s = s - (OWN_W+1)'(NUM_M);
        return s[OWN_W-1:0];
    endfunction

    assign req      = ~req_;
    assign rot_sh   = {1'b0, last} + (OWN_W+1)'(1);
    assign rot_full = {req, req} >> rot_sh;
    assign rot      = rot_full[NUM_M-1:0];

    // The top offset is the last owner itself: eligible when idle, never as "another" requester.
    always_comb begin
        // NOTE: combinational blocks use blocking assignments and give every output a default
        // first, so no path leaves a variable unassigned and no latch is inferred.
        oth_any = 1'b0;
        oth_off = '0;
        all_any = 1'b0;
        all_off = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            if (rot[k]) begin
                all_any = 1'b1;
                all_off = OWN_W'(k);
                if (k != NUM_M - 1) begin
                    oth_any = 1'b1;
                    oth_off = OWN_W'(k);
                end
            end
        end
    end

    assign oth_win   = off_to_idx(last, oth_off);
    assign all_win   = off_to_idx(last, all_off);
    assign owner_req = |(req & ~grnt_);
    assign preempt   = hold_en && (cnt == hold_max) && s_as_ && oth_any;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every register here is a control flop, so all of them take the async reset;
        // sequential state is always written with non-blocking assignments.
        if (!rst) begin
            state     <= IDLE;
            grnt_     <= '1;
            owner     <= '0;
            owner_vld <= 1'b0;
            cnt       <= '0;
            last      <= OWN_W'(NUM_M - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (all_any) begin
                        state     <= GRANT;
                        grnt_     <= ~(NUM_M'(1) << all_win);
                        owner     <= all_win;
                        owner_vld <= 1'b1;
                        last      <= all_win;
                        cnt       <= '0;
                    end
                end
                GRANT: begin
                    // Release wins over preemption; both pick the same next owner.
                    if (!owner_req || preempt) begin
                        cnt <= '0;
                        if (oth_any) begin
                            grnt_ <= ~(NUM_M'(1) << oth_win);
                            owner <= oth_win;
                            last  <= oth_win;
                        end else begin
                            state     <= IDLE;
                            grnt_     <= '1;
                            owner_vld <= 1'b0;
                        end
                    end else if (cnt != hold_max) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Scoreboard bench for yutorina_bus_arbiter: stimulus queues each expected grant change with the
// clock edge it must land on; monitors compare every grnt_ change against the queue head.
module tb_yutorina_bus_arbiter;

    typedef struct packed {
        int         at;
        logic [7:0] g;
        logic [2:0] o;
        logic       v;
        logic       co;
        int         tst;
        int         seq;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req4_ = 4'hF;
    logic       sas4_ = 1'b1;
    logic [3:0] grnt4_;
    logic [1:0] owner4;
    logic       vld4;
    logic [7:0] req8_ = 8'hFF;
    logic       sas8_ = 1'b1;
    logic [7:0] grnt8_;
    logic [2:0] owner8;
    logic       vld8;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   tst = 0;
    int   seq = 0;
    exp_t q4[$];
    exp_t q8[$];

    yutorina_bus_arbiter #(.NUM_M(4), .OWN_W(2), .MAX_HOLD(16), .CNT_W(5)) dut4 (
        .clk(clk), .rst(rst), .req_(req4_), .s_as_(sas4_),
        .grnt_(grnt4_), .owner(owner4), .owner_vld(vld4)
    );

    yutorina_bus_arbiter #(.NUM_M(8), .OWN_W(3), .MAX_HOLD(0), .CNT_W(5)) dut8 (
        .clk(clk), .rst(rst), .req_(req8_), .s_as_(sas8_),
        .grnt_(grnt8_), .owner(owner8), .owner_vld(vld8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int dut, input exp_t e, input logic [7:0] g,
                         input logic [2:0] o, input logic v);
        n_vec++;
        if (g !== e.g || v !== e.v || cyc != e.at || (e.co && o !== e.o)) begin
            n_bad++;
            $display("FAIL dut%0d t%0d.%0d: got grnt_=%b owner=%0d vld=%b edge=%0d, want grnt_=%b owner=%0d vld=%b edge=%0d",
                     dut, e.tst, e.seq, g, o, v, cyc, e.g, e.o, e.v, e.at);
        end
    endtask

    task automatic unexpected(input int dut, input logic [7:0] g);
        n_vec++;
        n_bad++;
        $display("FAIL dut%0d unexpected grant change: got grnt_=%b at edge %0d, want no change", dut, g, cyc);
    endtask

    always begin
        @(grnt4_);
        #1;
        if (q4.size() == 0) unexpected(4, {4'h0, grnt4_});
        else check(4, q4.pop_front(), {4'h0, grnt4_}, {1'b0, owner4}, vld4);
    end

    always begin
        @(grnt8_);
        #1;
        if (q8.size() == 0) unexpected(8, grnt8_);
        else check(8, q8.pop_front(), grnt8_, owner8, vld8);
    end

    // Expected change dt edges from now; owner is compared only where co is set.
    task automatic push4(input int dt, input logic [3:0] g, input logic [1:0] o,
                         input logic v, input logic co);
        exp_t e;
        e = '{at: cyc + dt, g: {4'h0, g}, o: {1'b0, o}, v: v, co: co, tst: tst, seq: seq};
        seq++;
        q4.push_back(e);
    endtask

    task automatic push8(input int dt, input logic [7:0] g, input logic [2:0] o,
                         input logic v, input logic co);
        exp_t e;
        e = '{at: cyc + dt, g: g, o: o, v: v, co: co, tst: tst, seq: seq};
        seq++;
        q8.push_back(e);
    endtask

    task automatic grant4(input int dt, input int m);
        logic [3:0] one;
        one = 4'b0001 << m;
        push4(dt, ~one, 2'(m), 1'b1, 1'b1);
    endtask

    task automatic grant8(input int dt, input int m);
        logic [7:0] one;
        one = 8'b0000_0001 << m;
        push8(dt, ~one, 3'(m), 1'b1, 1'b1);
    endtask

    // Leaves "now" 1 time unit after a rising edge; inputs set here are sampled on the next edge.
    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        go(1);
        #2 rst = 1'b0;
        go(2);
        rst = 1'b1;
    endtask

    initial begin
        // Power-up reset lands mid-cycle before the first edge.
        tst = 0;
        push4(0, 4'hF, 2'd0, 1'b0, 1'b1);
        push8(0, 8'hFF, 3'd0, 1'b0, 1'b1);
        #2 rst = 1'b0;
        go(2);
        rst = 1'b1;
        go(1);

        // Test 1: single request, one-edge latency, release to idle.
        tst = 1; seq = 0;
        req4_ = 4'b1110;
        push4(1, 4'b1110, 2'd0, 1'b1, 1'b1);
        go(1);
        req4_ = 4'b1111;
        push4(1, 4'b1111, 2'd0, 1'b0, 1'b0);
        go(2);

        // Test 2: all request, each owner drops req_ for one cycle after 3 owned cycles.
        do_reset();
        tst = 2; seq = 0;
        req4_ = 4'b0000;
        grant4(1, 0);
        go(1);
        for (int i = 0; i < 4; i++) begin
            go(2);
            req4_ = 4'b0000 | (4'b0001 << i);
            grant4(1, (i + 1) % 4);
            go(1);
            req4_ = 4'b0000;
        end
        req4_ = 4'b1111;
        push4(1, 4'b1111, 2'd0, 1'b0, 1'b0);
        go(2);

        // Test 3: the counter reads 0 in the first owned cycle, so the limit is seen on edge g+17.
        tst = 3; seq = 0;
        sas4_ = 1'b1;
        req4_ = 4'b1110;
        push4(1, 4'b1110, 2'd0, 1'b1, 1'b1);
        go(1);
        go(4);
        req4_ = 4'b1010;
        push4(13, 4'b1011, 2'd2, 1'b1, 1'b1);
        go(13);
        go(3);
        req4_ = 4'b1110;
        push4(1, 4'b1110, 2'd0, 1'b1, 1'b1);
        go(1);
        req4_ = 4'b1111;
        push4(1, 4'b1111, 2'd0, 1'b0, 1'b0);
        go(2);

        // Test 4: s_as_ low on edges g+14..g+20 holds off preemption until edge g+21.
        tst = 4; seq = 0;
        req4_ = 4'b1110;
        push4(1, 4'b1110, 2'd0, 1'b1, 1'b1);
        go(1);
        go(4);
        req4_ = 4'b1010;
        go(9);
        sas4_ = 1'b0;
        go(7);
        sas4_ = 1'b1;
        push4(1, 4'b1011, 2'd2, 1'b1, 1'b1);
        go(1);
        go(3);
        req4_ = 4'b1110;
        push4(1, 4'b1110, 2'd0, 1'b1, 1'b1);
        go(1);
        req4_ = 4'b1111;
        push4(1, 4'b1111, 2'd0, 1'b0, 1'b0);
        go(2);

        // Test 5: master 0 releases on the very edge its hold limit would preempt it.
        tst = 5; seq = 0;
        req4_ = 4'b1110;
        push4(1, 4'b1110, 2'd0, 1'b1, 1'b1);
        go(1);
        go(2);
        req4_ = 4'b1000;
        go(14);
        req4_ = 4'b1001;
        push4(1, 4'b1101, 2'd1, 1'b1, 1'b1);
        go(1);
        go(2);
        req4_ = 4'b1011;
        push4(1, 4'b1011, 2'd2, 1'b1, 1'b1);
        go(1);
        req4_ = 4'b1111;
        push4(1, 4'b1111, 2'd0, 1'b0, 1'b0);
        go(2);

        // Test 6: async reset mid-cycle while master 2 owns; then masters 1 and 2 request.
        tst = 6; seq = 0;
        req4_ = 4'b1011;
        push4(1, 4'b1011, 2'd2, 1'b1, 1'b1);
        go(1);
        go(1);
        push4(0, 4'b1111, 2'd0, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #2 req4_ = 4'b1111;
        go(2);
        rst = 1'b1;
        req4_ = 4'b1001;
        push4(1, 4'b1101, 2'd1, 1'b1, 1'b1);
        go(1);
        go(2);
        req4_ = 4'b1111;
        push4(1, 4'b1111, 2'd0, 1'b0, 1'b0);
        go(2);

        // Test 7: 8 masters, no hold limit: a 40-cycle hold under contention, then a full rotation.
        do_reset();
        tst = 7; seq = 0;
        req8_ = 8'h00;
        grant8(1, 0);
        go(1);
        go(40);
        for (int i = 0; i < 8; i++) begin
            req8_ = 8'h00 | (8'h01 << i);
            grant8(1, (i + 1) % 8);
            go(1);
            req8_ = 8'h00;
            go(2);
        end
        req8_ = 8'hFF;
        push8(1, 8'hFF, 3'd0, 1'b0, 1'b0);
        go(3);

        while (q4.size() > 0) begin
            exp_t e;
            e = q4.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL dut4 t%0d.%0d missing: got no change, want grnt_=%b at edge %0d", e.tst, e.seq, e.g, e.at);
        end
        while (q8.size() > 0) begin
            exp_t e;
            e = q8.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL dut8 t%0d.%0d missing: got no change, want grnt_=%b at edge %0d", e.tst, e.seq, e.g, e.at);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
